// File: rtl/sd_cmd_arbiter.sv
// sd_cmd_arbiter: picks one of two command sources (Wishbone host or the
// BD/DMA engine) and owns the SD command path until the command completes,
// times out or is aborted.
//
// Optional build macro: SD_CMD_ARB_RR_EN
//   defined     -> round-robin tie break using a last-grant register
//   not defined -> fixed priority, the host wins every tie
//
// Request/grant handshake (both sources):
//   req_x_i is a level held by the requester. It is sampled only in IDLE.
//   ack_x_o is a one-cycle pulse in the ISSUE cycle. The requester must
//   drop req_x_i after seeing ack_x_o, or it is granted again on the next
//   return to IDLE. cpl_x_o is a one-cycle pulse when the owned command
//   ends, either normally or by timeout (tmo_err_o pulses with it). An
//   abort ends ownership silently, with no ack, cpl or err pulse.
module sd_cmd_arbiter #(
   parameter int TMO_W = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n_i,
   input  logic             req_h_i,
   input  logic [15:0]      set_h_i,
   input  logic [31:0]      arg_h_i,
   input  logic             req_d_i,
   input  logic [15:0]      set_d_i,
   input  logic [31:0]      arg_d_i,
   input  logic             cmd_done_i,
   input  logic             abort_i,
   input  logic [TMO_W-1:0] time_out_i,
   output logic             ack_h_o,
   output logic             ack_d_o,
   output logic             cpl_h_o,
   output logic             cpl_d_o,
   output logic             tmo_err_o,
   output logic             new_cmd_o,
   output logic [15:0]      cmd_setting_o,
   output logic [31:0]      argument_o,
   output logic             busy_o,
   output logic             owner_o,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_nxt;
   logic [TMO_W-1:0] tmo_cnt_q;
   logic             owner_q;
   logic [15:0]      setting_q;
   logic [31:0]      argument_q;

   logic             grant;
   logic             grant_dma;
   logic             pick_dma;
   logic             tmo_hit;

   // A counter of zero means the timeout is disabled for this command.
   assign tmo_hit = (tmo_cnt_q == TMO_W'(1));

`ifdef SD_CMD_ARB_RR_EN
   logic last_dma_q;

   // Tie break: on simultaneous requests the source not granted last wins.
   always_comb begin
      pick_dma = 1'b0;
      if (req_d_i && !req_h_i)
         pick_dma = 1'b1;
      else if (req_d_i && req_h_i)
         pick_dma = !last_dma_q;
   end

   // Remember who was granted last; reset to DMA so the host wins the first tie.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i)
         last_dma_q <= 1'b1;
      else if (grant)
         last_dma_q <= grant_dma;
   end
`else
   // Tie break: the host always wins; DMA only gets the path when the host is quiet.
   always_comb begin
      pick_dma = 1'b0;
      if (req_d_i && !req_h_i)
         pick_dma = 1'b1;
   end
`endif

   // State register.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i)
         state_q <= ST_IDLE;
      else
         state_q <= state_nxt;
   end

   // Next-state and pulse outputs. Completion is combinational on cmd_done_i
   // so the owner sees cpl in the very cycle the command master reports done.
   always_comb begin
      state_nxt = state_q;
      grant     = 1'b0;
      grant_dma = 1'b0;
      ack_h_o   = 1'b0;
      ack_d_o   = 1'b0;
      cpl_h_o   = 1'b0;
      cpl_d_o   = 1'b0;
      tmo_err_o = 1'b0;
      new_cmd_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!abort_i && (req_h_i || req_d_i)) begin
               grant     = 1'b1;
               grant_dma = pick_dma;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (abort_i) begin
               state_nxt = ST_IDLE;
            end else begin
               new_cmd_o = 1'b1;
               ack_h_o   = !owner_q;
               ack_d_o   = owner_q;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (abort_i) begin
               state_nxt = ST_IDLE;
            end else if (cmd_done_i) begin
               // Done beats a coincident timeout: no error is flagged.
               cpl_h_o   = !owner_q;
               cpl_d_o   = owner_q;
               state_nxt = ST_IDLE;
            end else if (tmo_hit) begin
               cpl_h_o   = !owner_q;
               cpl_d_o   = owner_q;
               tmo_err_o = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Timeout counter: loaded when the command issues, then counts down to
   // 1 and parks at 0 so a disabled timeout never wraps into a false expiry.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i)
         tmo_cnt_q <= '0;
      else if (state_q == ST_ISSUE && !abort_i)
         tmo_cnt_q <= time_out_i;
      else if (state_q == ST_WAIT && tmo_cnt_q != '0)
         tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
   end

   // Capture the winner's command and ownership at grant; held through abort.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         owner_q    <= 1'b0;
         setting_q  <= '0;
         argument_q <= '0;
      end else if (grant) begin
         owner_q    <= grant_dma;
         setting_q  <= grant_dma ? set_d_i : set_h_i;
         argument_q <= grant_dma ? arg_d_i : arg_h_i;
      end
   end

   assign cmd_setting_o = setting_q;
   assign argument_o    = argument_q;
   assign owner_o       = owner_q;
   assign busy_o        = (state_q != ST_IDLE);
   assign state_o       = state_q;

endmodule
